// File: rtl/systolic_mac_pe_os.sv
// systolic_mac_pe_os
// Output-stationary MAC processing element for the systolic matmul array.
// Operand a travels east and operand b travels south, each with a one-cycle
// register stage. The PE accumulates a*b while both operands are valid.
// On res_load the finished tile is copied into a result register that sits on
// a column drain chain, so the next tile can accumulate while earlier results
// shift south toward the array edge.
`timescale 1ns/1ps

module systolic_mac_pe_os #(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 20,
  parameter int SATURATE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] a_in,
  input  logic                     a_valid_in,
  input  logic signed [DATA_W-1:0] b_in,
  input  logic                     b_valid_in,
  input  logic                     clear,
  input  logic                     res_load,
  input  logic                     shift_en,
  input  logic signed [ACC_W-1:0]  psum_in,
  input  logic                     psum_valid_in,
  output logic signed [DATA_W-1:0] a_out,
  output logic                     a_valid_out,
  output logic signed [DATA_W-1:0] b_out,
  output logic                     b_valid_out,
  output logic signed [ACC_W-1:0]  psum_out,
  output logic                     psum_valid_out,
  output logic                     acc_ovf
);

  localparam int PROD_W = 2 * DATA_W;

  // Signed limits the accumulator clamps to when saturation is enabled.
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W-1:0]  acc;
  logic signed [PROD_W-1:0] a_ext;
  logic signed [PROD_W-1:0] b_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W:0]    prod_ext;
  logic signed [ACC_W-1:0]  base;
  logic signed [ACC_W:0]    base_ext;
  logic signed [ACC_W:0]    sum;
  logic signed [ACC_W-1:0]  acc_next;
  logic                     fire;
  logic                     restart;
  logic                     ovf_now;
  logic                     ovf_next;

  // Compute this cycle's product, the accumulator update and the overflow flag.
  // The sum is one bit wider than the accumulator so that a disagreement
  // between its top two bits identifies a signed overflow.
  always_comb begin
    fire     = a_valid_in & b_valid_in;
    restart  = clear | res_load;
    a_ext    = {{DATA_W{a_in[DATA_W-1]}}, a_in};
    b_ext    = {{DATA_W{b_in[DATA_W-1]}}, b_in};
    prod     = a_ext * b_ext;
    prod_ext = {{(ACC_W + 1 - PROD_W){prod[PROD_W-1]}}, prod};
    base     = restart ? '0 : acc;
    base_ext = {base[ACC_W-1], base};
    sum      = base_ext + prod_ext;
    ovf_now  = fire & (sum[ACC_W] ^ sum[ACC_W-1]);
    acc_next = base;
    if (fire) begin
      if (ovf_now && (SATURATE != 0)) begin
        acc_next = sum[ACC_W] ? ACC_MIN : ACC_MAX;
      end else begin
        acc_next = sum[ACC_W-1:0];
      end
    end
    ovf_next = restart ? ovf_now : (acc_ovf | ovf_now);
  end

  // Forward both operands and their qualifiers to the neighbours every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_out       <= '0;
      a_valid_out <= 1'b0;
      b_out       <= '0;
      b_valid_out <= 1'b0;
    end else begin
      a_out       <= a_in;
      a_valid_out <= a_valid_in;
      b_out       <= b_in;
      b_valid_out <= b_valid_in;
    end
  end

  // Accumulator and its sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      acc_ovf <= 1'b0;
    end else begin
      acc     <= acc_next;
      acc_ovf <= ovf_next;
    end
  end

  // Result register on the drain chain; a tile load takes priority over a shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psum_out       <= '0;
      psum_valid_out <= 1'b0;
    end else if (res_load) begin
      psum_out       <= acc;
      psum_valid_out <= 1'b1;
    end else if (shift_en) begin
      psum_out       <= psum_in;
      psum_valid_out <= psum_valid_in;
    end
  end

endmodule

// File: tb/tb_systolic_mac_pe_os.sv
// tb_systolic_mac_pe_os
// Directed bench for the output-stationary MAC PE: a table of single-cycle
// vectors for the default PE, plus hand sequences for saturation/wrap,
// a three-PE drain column and asynchronous reset in the middle of a drain.
`timescale 1ns/1ps

module tb_systolic_mac_pe_os;

  localparam int DW = 8;
  localparam int AW = 20;
  localparam int NV = 28;

  logic clk = 1'b0;
  logic rst;

  // Shared stimulus for the three stand-alone PEs
  logic signed [DW-1:0] a, b;
  logic                 av, bv, clr, ld, sh, pvin;
  logic signed [AW-1:0] pin;

  // Default PE (ACC_W=20, saturating)
  logic signed [DW-1:0] d_aout, d_bout;
  logic                 d_av, d_bv, d_pv, d_ovf;
  logic signed [AW-1:0] d_pout;

  // 16-bit saturating PE and 16-bit wrapping PE
  logic signed [DW-1:0] s_aout, s_bout, w_aout, w_bout;
  logic                 s_av, s_bv, s_pv, s_ovf, w_av, w_bv, w_pv, w_ovf;
  logic signed [15:0]   s_pout, w_pout;

  // Three-PE drain column
  logic signed [DW-1:0] ca [3];
  logic signed [DW-1:0] cb;
  logic                 cav, cbv, cclr, cld, csh;
  logic signed [AW-1:0] ctop_pin;
  logic                 ctop_pv;
  logic signed [AW-1:0] cpout [3];
  logic                 cpv [3];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic signed [DW-1:0] a;
    logic                 av;
    logic signed [DW-1:0] b;
    logic                 bv;
    logic                 clr;
    logic                 ld;
    logic                 sh;
    logic signed [AW-1:0] pin;
    logic                 pvin;
    int                   exp_pout;
    logic                 exp_pv;
    logic                 exp_ovf;
  } vec_t;

  vec_t vecs [NV];

  always #5 clk = ~clk;

  systolic_mac_pe_os #(.DATA_W(DW), .ACC_W(AW), .SATURATE(1)) u_def (
    .clk(clk), .rst(rst), .a_in(a), .a_valid_in(av), .b_in(b), .b_valid_in(bv),
    .clear(clr), .res_load(ld), .shift_en(sh), .psum_in(pin), .psum_valid_in(pvin),
    .a_out(d_aout), .a_valid_out(d_av), .b_out(d_bout), .b_valid_out(d_bv),
    .psum_out(d_pout), .psum_valid_out(d_pv), .acc_ovf(d_ovf));

  systolic_mac_pe_os #(.DATA_W(DW), .ACC_W(16), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .a_in(a), .a_valid_in(av), .b_in(b), .b_valid_in(bv),
    .clear(clr), .res_load(ld), .shift_en(sh), .psum_in(pin[15:0]), .psum_valid_in(pvin),
    .a_out(s_aout), .a_valid_out(s_av), .b_out(s_bout), .b_valid_out(s_bv),
    .psum_out(s_pout), .psum_valid_out(s_pv), .acc_ovf(s_ovf));

  systolic_mac_pe_os #(.DATA_W(DW), .ACC_W(16), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .a_in(a), .a_valid_in(av), .b_in(b), .b_valid_in(bv),
    .clear(clr), .res_load(ld), .shift_en(sh), .psum_in(pin[15:0]), .psum_valid_in(pvin),
    .a_out(w_aout), .a_valid_out(w_av), .b_out(w_bout), .b_valid_out(w_bv),
    .psum_out(w_pout), .psum_valid_out(w_pv), .acc_ovf(w_ovf));

  for (genvar i = 0; i < 3; i++) begin : g_col
    logic signed [AW-1:0] pin_w;
    logic                 pv_w;
    logic signed [DW-1:0] ao, bo;
    logic                 avo, bvo, ovf;
    if (i == 0) begin : g_top
      assign pin_w = ctop_pin;
      assign pv_w  = ctop_pv;
    end else begin : g_link
      assign pin_w = cpout[i-1];
      assign pv_w  = cpv[i-1];
    end
    systolic_mac_pe_os #(.DATA_W(DW), .ACC_W(AW), .SATURATE(1)) u_pe (
      .clk(clk), .rst(rst), .a_in(ca[i]), .a_valid_in(cav), .b_in(cb), .b_valid_in(cbv),
      .clear(cclr), .res_load(cld), .shift_en(csh), .psum_in(pin_w), .psum_valid_in(pv_w),
      .a_out(ao), .a_valid_out(avo), .b_out(bo), .b_valid_out(bvo),
      .psum_out(cpout[i]), .psum_valid_out(cpv[i]), .acc_ovf(ovf));
  end

  function automatic vec_t mk(input int va, input logic vav, input int vb, input logic vbv,
                              input logic vclr, input logic vld, input logic vsh,
                              input int vpin, input logic vpvin,
                              input int epout, input logic epv, input logic eovf);
    vec_t v;
    v.a = DW'(va);      v.av = vav;   v.b = DW'(vb);   v.bv = vbv;
    v.clr = vclr;       v.ld = vld;   v.sh = vsh;
    v.pin = AW'(vpin);  v.pvin = vpvin;
    v.exp_pout = epout; v.exp_pv = epv; v.exp_ovf = eovf;
    return v;
  endfunction

  task automatic check_output(input string name, input logic signed [31:0] act,
                              input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input vec_t v);
    a = v.a; av = v.av; b = v.b; bv = v.bv;
    clr = v.clr; ld = v.ld; sh = v.sh; pin = v.pin; pvin = v.pvin;
    tick();
  endtask

  task automatic idle_inputs();
    a = '0; av = 0; b = '0; bv = 0; clr = 0; ld = 0; sh = 0; pin = '0; pvin = 0;
    ca[0] = '0; ca[1] = '0; ca[2] = '0; cb = '0; cav = 0; cbv = 0;
    cclr = 0; cld = 0; csh = 0; ctop_pin = '0; ctop_pv = 0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    //            a   av  b   bv clr ld sh  pin  pv  pout  pv ovf
    vecs[0]  = mk(0,   0, 0,   0, 1, 0, 0,   0,  0,    0, 0, 0);
    vecs[1]  = mk(3,   1, 4,   1, 0, 0, 0,   0,  0,    0, 0, 0);
    vecs[2]  = mk(-2,  1, 5,   1, 0, 0, 0,   0,  0,    0, 0, 0);
    vecs[3]  = mk(7,   1, -1,  1, 0, 0, 0,   0,  0,    0, 0, 0);
    vecs[4]  = mk(0,   0, 0,   0, 0, 1, 0,   0,  0,   -5, 1, 0);
    vecs[5]  = mk(10,  1, 10,  0, 0, 0, 0,   0,  0,   -5, 1, 0);
    vecs[6]  = mk(10,  1, 10,  0, 0, 0, 0,   0,  0,   -5, 1, 0);
    vecs[7]  = mk(10,  1, 10,  1, 0, 0, 0,   0,  0,   -5, 1, 0);
    vecs[8]  = mk(0,   0, 0,   0, 0, 1, 0,   0,  0,  100, 1, 0);
    vecs[9]  = mk(2,   1, 3,   1, 0, 0, 0,   0,  0,  100, 1, 0);
    vecs[10] = mk(4,   1, 4,   1, 0, 0, 0,   0,  0,  100, 1, 0);
    vecs[11] = mk(5,   1, 5,   1, 0, 1, 0,   0,  0,   22, 1, 0);
    vecs[12] = mk(1,   1, 1,   1, 0, 0, 0,   0,  0,   22, 1, 0);
    vecs[13] = mk(0,   0, 0,   0, 0, 1, 0,   0,  0,   26, 1, 0);
    vecs[14] = mk(9,   1, 9,   1, 0, 0, 0,   0,  0,   26, 1, 0);
    vecs[15] = mk(0,   0, 0,   0, 0, 1, 1, 999,  1,   81, 1, 0);
    vecs[16] = mk(0,   0, 0,   0, 0, 0, 1, 999,  1,  999, 1, 0);
    vecs[17] = mk(0,   0, 0,   0, 0, 0, 1,  -7,  0,   -7, 0, 0);
    vecs[18] = mk(0,   0, 0,   0, 0, 0, 0,   5,  1,   -7, 0, 0);
    vecs[19] = mk(2,   1, 2,   1, 0, 0, 0,   0,  0,   -7, 0, 0);
    vecs[20] = mk(0,   0, 0,   0, 1, 1, 0,   0,  0,    4, 1, 0);
    vecs[21] = mk(0,   0, 0,   0, 0, 1, 0,   0,  0,    0, 1, 0);
    vecs[22] = mk(3,   1, 3,   1, 0, 0, 0,   0,  0,    0, 1, 0);
    vecs[23] = mk(2,   1, 2,   1, 1, 0, 0,   0,  0,    0, 1, 0);
    vecs[24] = mk(0,   0, 0,   0, 0, 1, 0,   0,  0,    4, 1, 0);
    vecs[25] = mk(-128,1, 127, 1, 0, 0, 0,   0,  0,    4, 1, 0);
    vecs[26] = mk(-128,1, -128,1, 0, 0, 0,   0,  0,    4, 1, 0);
    vecs[27] = mk(0,   0, 0,   0, 0, 1, 0,   0,  0,  128, 1, 0);

    // Reset with busy inputs: everything must stay at zero
    idle_inputs();
    rst = 1;
    a = 8'sd5; av = 1; b = 8'sd6; bv = 1; ld = 1; sh = 1; pin = 20'sd77; pvin = 1;
    repeat (3) tick();
    check_output("reset a_out", d_aout, 0);
    check_output("reset a_valid_out", d_av, 0);
    check_output("reset b_out", d_bout, 0);
    check_output("reset b_valid_out", d_bv, 0);
    check_output("reset psum_out", d_pout, 0);
    check_output("reset psum_valid_out", d_pv, 0);
    check_output("reset acc_ovf", d_ovf, 0);
    check_output("reset column psum_valid_out", cpv[2], 0);
    idle_inputs();
    rst = 0;
    tick();

    // Table-driven vectors on the default PE
    for (int i = 0; i < NV; i++) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("vec%0d psum_out", i), d_pout, vecs[i].exp_pout);
      check_output($sformatf("vec%0d psum_valid_out", i), d_pv, vecs[i].exp_pv);
      check_output($sformatf("vec%0d acc_ovf", i), d_ovf, vecs[i].exp_ovf);
      check_output($sformatf("vec%0d a_out", i), d_aout, vecs[i].a);
      check_output($sformatf("vec%0d a_valid_out", i), d_av, vecs[i].av);
      check_output($sformatf("vec%0d b_out", i), d_bout, vecs[i].b);
      check_output($sformatf("vec%0d b_valid_out", i), d_bv, vecs[i].bv);
    end
    idle_inputs();

    // Positive overflow: 16384 * 3 against a 16-bit accumulator
    clr = 1; tick(); clr = 0;
    a = -8'sd128; b = -8'sd128; av = 1; bv = 1;
    tick();
    check_output("sat p1 ovf", s_ovf, 0);
    check_output("wrap p1 ovf", w_ovf, 0);
    tick();
    check_output("sat p2 ovf", s_ovf, 1);
    check_output("wrap p2 ovf", w_ovf, 1);
    tick();
    av = 0; bv = 0;
    tick();
    check_output("sat ovf sticky", s_ovf, 1);
    check_output("wrap ovf sticky", w_ovf, 1);
    check_output("wide no ovf", d_ovf, 0);
    ld = 1; tick(); ld = 0;
    check_output("sat pos psum_out", s_pout, 32767);
    check_output("wrap pos psum_out", w_pout, -16384);
    check_output("wide pos psum_out", d_pout, 49152);
    check_output("sat ovf after load", s_ovf, 0);
    check_output("wrap ovf after load", w_ovf, 0);

    // Negative overflow: -16256 * 3
    a = -8'sd128; b = 8'sd127; av = 1; bv = 1;
    tick();
    tick();
    check_output("sat n2 ovf", s_ovf, 0);
    tick();
    check_output("sat n3 ovf", s_ovf, 1);
    check_output("wrap n3 ovf", w_ovf, 1);
    av = 0; bv = 0; ld = 1; tick(); ld = 0;
    check_output("sat neg psum_out", s_pout, -32768);
    check_output("wrap neg psum_out", w_pout, 16768);
    check_output("wide neg psum_out", d_pout, -48768);
    idle_inputs();

    // Drain column: load 11, 22, 33 then shift them out the bottom
    ca[0] = 8'sd11; ca[1] = 8'sd22; ca[2] = 8'sd33; cb = 8'sd1;
    cav = 1; cbv = 1; cclr = 1;
    tick();
    cav = 0; cbv = 0; cclr = 0; cld = 1;
    tick();
    cld = 0;
    check_output("col load top", cpout[0], 11);
    check_output("col load mid", cpout[1], 22);
    check_output("col drain 0", cpout[2], 33);
    check_output("col drain 0 valid", cpv[2], 1);
    csh = 1;
    tick();
    check_output("col drain 1", cpout[2], 22);
    check_output("col drain 1 valid", cpv[2], 1);
    tick();
    check_output("col drain 2", cpout[2], 11);
    check_output("col drain 2 valid", cpv[2], 1);
    tick();
    check_output("col drain 3 valid", cpv[2], 0);
    check_output("col drain 3 data", cpout[2], 0);

    // Load and shift together: the tile load wins over the incoming psum
    cav = 1; cbv = 1; ca[0] = 8'sd4; ca[1] = 8'sd5; ca[2] = 8'sd6; cb = 8'sd2; cclr = 1; csh = 0;
    tick();
    cav = 0; cbv = 0; cclr = 0; cld = 1; csh = 1;
    tick();
    cld = 0; csh = 0;
    check_output("col load+shift bottom", cpout[2], 12);
    check_output("col load+shift mid", cpout[1], 10);

    // Reload, shift once, then reset asynchronously between clock edges
    cav = 1; cbv = 1; ca[0] = 8'sd11; ca[1] = 8'sd22; ca[2] = 8'sd33; cb = 8'sd1; cclr = 1;
    tick();
    cav = 0; cbv = 0; cclr = 0; cld = 1;
    tick();
    cld = 0; csh = 1;
    a = 8'sd9; av = 1;
    tick();
    check_output("pre-reset drain", cpout[2], 22);
    check_output("pre-reset a_out", d_aout, 9);
    #2;
    rst = 1;
    #1;
    check_output("async rst col bottom", cpout[2], 0);
    check_output("async rst col bottom valid", cpv[2], 0);
    check_output("async rst col mid valid", cpv[1], 0);
    check_output("async rst a_out", d_aout, 0);
    check_output("async rst a_valid_out", d_av, 0);
    check_output("async rst psum_valid_out", d_pv, 0);
    check_output("async rst psum_out", d_pout, 0);
    #3;
    idle_inputs();
    rst = 0;
    cld = 1; ld = 1;
    tick();
    cld = 0; ld = 0;
    check_output("post-reset col psum_out", cpout[2], 0);
    check_output("post-reset col psum_valid_out", cpv[2], 1);
    check_output("post-reset psum_out", d_pout, 0);
    check_output("post-reset psum_valid_out", d_pv, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_mac_pe_os.md
Name: systolic_mac_pe_os

Overview:
- Parametrised output-stationary MAC processing element for the next-generation systolic matmul array. It replaces the fixed 8-bit, always-accumulating PE.
- Adds per-operand valid qualification, synchronous tile clear and optional saturating accumulation with a sticky overflow flag.
- Adds a double-buffered result register on a column drain chain, so tile N+1 accumulates while tile N shifts out.
- Instantiated ROWS x COLS in the array: a flows east, b flows south, results drain south via psum_in/psum_out.

Parameters:
- DATA_W, 8: signed operand width for a and b.
- ACC_W, 20: signed accumulator and result width; must be >= 2*DATA_W.
- SATURATE, 1: 1 = clamp accumulator at signed limits and flag overflow; 0 = two's-complement wrap, overflow still flagged.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- a_in, input, DATA_W: signed operand from the west neighbour.
- a_valid_in, input, 1: a_in qualifier.
- b_in, input, DATA_W: signed operand from the north neighbour.
- b_valid_in, input, 1: b_in qualifier.
- clear, input, 1: start of a new tile; zeroes the accumulator.
- res_load, input, 1: pulse; moves the finished accumulator into the result register.
- shift_en, input, 1: advances the drain chain by one position.
- psum_in, input, ACC_W: result from the north neighbour's psum_out.
- psum_valid_in, input, 1: psum_in qualifier.
- a_out, output, DATA_W: registered a_in to the east neighbour.
- a_valid_out, output, 1: registered a_valid_in.
- b_out, output, DATA_W: registered b_in to the south neighbour.
- b_valid_out, output, 1: registered b_valid_in.
- psum_out, output, ACC_W: result register, toward the south and array edge.
- psum_valid_out, output, 1: result register valid.
- acc_ovf, output, 1: sticky overflow for the current accumulation.

Behaviour:
- Reset:
  - All outputs are 0: a_out, b_out, both valid outs, psum_out, psum_valid_out, acc_ovf.
  - The internal accumulator is 0.
  - Reset asserted mid-tile or mid-drain discards all state immediately. No partial result survives.
- Forwarding:
  - Every cycle, a_out<=a_in, a_valid_out<=a_valid_in, b_out<=b_in, b_valid_out<=b_valid_in.
  - Latency is 1 cycle and is unconditional; data moves even when its valid is 0.
- MAC fire:
  - fire = a_valid_in & b_valid_in.
  - prod = a_in*b_in, full signed 2*DATA_W bits, sign-extended to ACC_W.
  - sum = base + prod, computed at ACC_W+1 bits. base is 0 if clear or res_load is high this cycle, else the accumulator.
  - If fire=0, the accumulator is set to base.
- Overflow:
  - Overflow occurs when bit ACC_W of sum differs from bit ACC_W-1.
  - With SATURATE=1, the accumulator clamps to +(2^(ACC_W-1)-1) or -2^(ACC_W-1).
  - With SATURATE=0, the accumulator takes the low ACC_W bits.
  - Either way, acc_ovf<=1.
- acc_ovf:
  - Sticky until the next clear or res_load.
  - When clear or res_load is high, acc_ovf takes only that cycle's overflow.
- clear with fire in the same cycle: the accumulator becomes prod, so the first product of the tile is not lost.
- res_load:
  - psum_out<=the accumulator value before this edge (this cycle's product is excluded), psum_valid_out<=1.
  - The accumulator restarts as if clear were high, so a same-cycle fire begins the next tile.
- shift_en (without res_load): psum_out<=psum_in, psum_valid_out<=psum_valid_in.
- res_load with shift_en in the same cycle: res_load wins; psum_in is dropped. Controller must not overlap them; the bench checks the priority.
- Neither res_load nor shift_en: psum_out and psum_valid_out hold.
- clear with res_load in the same cycle: same as res_load alone.
- Accumulator is never directly observable except via res_load.

Test Plan:
- Basic tile (defaults): clear; fire pairs (3,4), (-2,5), (7,-1); res_load next cycle -> psum_out=-5, psum_valid_out=1 one cycle after res_load, acc_ovf=0.
- Valid gating: a=10,b=10 with b_valid_in=0 for 2 cycles, then both valid once; res_load -> psum_out=100. Check b_out=10 and b_valid_out=0 forwarded one cycle after each input.
- Saturation (ACC_W=16, SATURATE=1): clear, then (-128)*(-128) three times; res_load -> psum_out=32767, acc_ovf=1 from the second product. Repeat with SATURATE=0 -> psum_out=-16384, acc_ovf=1.
- Overlap: tile with 2*3 then 4*4, res_load coincident with the next tile's first fire 5*5; then 1*1 and res_load -> first psum_out=22, second psum_out=26.
- Drain chain: 3-PE column loaded with 11, 22, 33 (north to south); shift_en for 3 cycles, top psum_in=0 and psum_valid_in=0 -> bottom psum_out sequence 33, 22, 11, then valid falls to 0. Also res_load+shift_en in the same cycle -> load value wins.
- Reset mid-drain: assert rst asynchronously between clock edges during the shift sequence -> all outputs 0 immediately, before the next clock edge; after release, res_load with no fires -> psum_out=0, psum_valid_out=1.
